multu_sequencer: RTL and testbench

Iterative unsigned multiply sequencer that executes MIPS `multu` and owns the architectural HI/LO registers read by `mfhi`/`mflo`. It sits beside the single-cycle datapath:
- the controller's decoded `multu` pulses `start`;
- `mfhi`/`mflo` raise `mf_req`;
- `stall` freezes the PC and register-file write while a conflicting instruction waits for an in-flight multiply.

---
 rtl/multu_sequencer.sv | 135 +++++++++++++
 tb/tb_multu_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multu_sequencer.sv
// Iterative unsigned multiplier for MIPS multu; owns HI/LO and stalls mfhi/mflo and multu while busy.
// Optional MULTU_RADIX4_EN macro: radix-4 iteration (WIDTH/2 cycles) instead of radix-2 (WIDTH cycles).
module multu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULTU_RADIX4_EN
  localparam int unsigned ITERS = WIDTH / 2;
`else
  localparam int unsigned ITERS = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam int unsigned ACC_W = 2 * WIDTH;

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
    $error("multu_sequencer: WIDTH must be even and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  // A start is only taken when no multiply is in flight (IDLE or DONE).
  assign accept = start & (state != S_RUN);
  assign last   = (cnt == CNT_W'(ITERS - 1));
  assign stall  = busy & (start | mf_req);

`ifdef MULTU_RADIX4_EN
  logic [WIDTH+1:0] mcand3;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;

  // 3*mcand is formed once at accept so each step is a single add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand3 <= '0;
    end else if (accept) begin
      mcand3 <= {2'b00, op_a} + {1'b0, op_a, 1'b0};
    end
  end

  // Retire two multiplier bits: add k*mcand for k=acc[1:0], then shift right by 2.
  always_comb begin
    addend = '0;
    case (acc[1:0])
      2'd1:    addend = {2'b00, mcand};
      2'd2:    addend = {1'b0, mcand, 1'b0};
      2'd3:    addend = mcand3;
      default: addend = '0;
    endcase
    sum      = {2'b00, acc[ACC_W-1:WIDTH]} + addend;
    acc_next = {sum, acc[WIDTH-1:2]};
  end
`else
  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  // Retire one multiplier bit; the add carry becomes the new accumulator MSB.
  always_comb begin
    addend   = acc[0] ? {1'b0, mcand} : (WIDTH + 1)'(0);
    sum      = {1'b0, acc[ACC_W-1:WIDTH]} + addend;
    acc_next = {sum, acc[WIDTH-1:1]};
  end
`endif

  // Sequencer FSM with registered busy/done and HI/LO written only on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (accept) begin
            mcand <= op_a;
            acc   <= {{WIDTH{1'b0}}, op_b};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          if (last) begin
            hi    <= acc_next[ACC_W-1:WIDTH];
            lo    <= acc_next[WIDTH-1:0];
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Self-checking bench for multu_sequencer: vector table, hand-written corner sequences, random operands.
module tb_multu_sequencer;

`ifdef MULTU_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mf_req = 1'b0;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  multu_sequencer #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .mf_req (mf_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply from a non-busy state, scramble the operand inputs after accept,
  // and check latency, product and the one-cycle done pulse.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input string nm);
    int n;
    start = 1'b1; op_a = a; op_b = b;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < TIMEOUT) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(LAT));
    chk({nm, " hilo"}, {hi, lo}, p);
    tick();
    chk({nm, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t vt[7];
    int   n, m, bad, bad_lo, chg, dcnt;
    logic [63:0] p1, p2;

    vt[0] = '{"basic",   32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060};
    vt[1] = '{"max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vt[2] = '{"zero",    32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    vt[3] = '{"one",     32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001};
    vt[4] = '{"maxx2",   32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
    vt[5] = '{"msb",     32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vt[6] = '{"cross32", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    // Reset state, including stall suppression while idle.
    start = 1'b1; mf_req = 1'b1;
    #12;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    start = 1'b0; mf_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_mul(vt[i].a, vt[i].b, vt[i].p, vt[i].nm);
    end

    // mflo held from cycle 3 of a RUN; prior lo=0x55.
    run_mul(32'h55, 32'h1, 64'h55, "prime");
    start = 1'b1; op_a = 32'h0000_1234; op_b = 32'h0000_5678;
    tick();
    start = 1'b0;
    tick();
    tick();
    mf_req = 1'b1;
    #1;
    n = 0; bad = 0; bad_lo = 0;
    while (!done && n < TIMEOUT) begin
      if (stall !== 1'b1) bad++;
      if (lo !== 32'h55) bad_lo++;
      tick();
      n++;
    end
    chk("mflo stall while busy", 64'(bad), 64'd0);
    chk("mflo old lo while busy", 64'(bad_lo), 64'd0);
    chk("mflo stall at done", 64'(stall), 64'd0);
    chk("mflo lo at done", 64'(lo), 64'h0626_0060);
    mf_req = 1'b0;
    tick();

    // Back-to-back multu: second start held while busy, accepted from DONE.
    p1 = 64'(32'hCAFE_F00D) * 64'(32'h1234_5678);
    p2 = 64'(32'h0BAD_C0DE) * 64'(32'h7777_9999);
    start = 1'b1; op_a = 32'hCAFE_F00D; op_b = 32'h1234_5678;
    tick();
    op_a = 32'h0BAD_C0DE; op_b = 32'h7777_9999;
    #1;
    n = 0; bad = 0;
    while (!done && n < TIMEOUT) begin
      if (stall !== 1'b1) bad++;
      tick();
      n++;
    end
    chk("b2b stall while busy", 64'(bad), 64'd0);
    chk("b2b first latency", 64'(n), 64'(LAT));
    chk("b2b first hilo", {hi, lo}, p1);
    chk("b2b stall at done", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    chk("b2b second accepted", 64'(busy), 64'd1);
    m = 1; chg = 0;
    while (!done && m < TIMEOUT) begin
      if ({hi, lo} !== p1) chg++;
      tick();
      m++;
    end
    chk("b2b hilo held", 64'(chg), 64'd0);
    chk("b2b spacing", 64'(m), 64'(LAT + 1));
    chk("b2b second hilo", {hi, lo}, p2);
    tick();

    // Reset asserted mid-RUN discards the product and clears HI/LO at once.
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst hilo", {hi, lo}, 64'd0);
    mf_req = 1'b1;
    #1;
    chk("midrst stall", 64'(stall), 64'd0);
    mf_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("midrst no done", 64'(dcnt), 64'd0);
    chk("midrst hilo after", {hi, lo}, 64'd0);

    // Random operands against plain 64-bit arithmetic.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'(a >> $urandom_range(0, 31));
        default: ;
      endcase
      run_mul(a, b, 64'(a) * 64'(b), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
